// File: rtl/ex_muldiv_unit_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit.
// The function-code constants are the same ones used by the ALU control
// decoder and the hazard unit, so all three agree on the encodings.
package ex_muldiv_unit_pkg;

    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;
    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MTHI  = 6'b010001;
    localparam logic [5:0] FN_MTLO  = 6'b010011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } state_t;

    // Any code that touches HI/LO and therefore must wait for an in-flight op
    function automatic logic is_muldiv_fn(input logic [5:0] fn);
        return (fn == FN_MULT) || (fn == FN_MULTU) || (fn == FN_DIV) || (fn == FN_DIVU) ||
               (fn == FN_MFHI) || (fn == FN_MFLO) || (fn == FN_MTHI) || (fn == FN_MTLO);
    endfunction

endpackage

// File: rtl/ex_muldiv_unit_iter_core.sv
// Bit-serial multiply/divide datapath: one radix-2 step per enabled cycle.
// Multiply: {acc, q} is the product shift register, LSB-first shift-add.
// Divide: acc is the partial remainder, q shifts the dividend out and the
// quotient in (restoring shift-subtract). Operands arrive as magnitudes.
module muldiv_iter_core #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              step,
    input  logic              div_mode,
    input  logic [DATA_W-1:0] a_mag,
    input  logic [DATA_W-1:0] b_mag,
    output logic [DATA_W-1:0] acc_nxt,
    output logic [DATA_W-1:0] q_nxt
);

    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] q_q, q_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [DATA_W:0]   sum;
    logic [DATA_W:0]   shifted;
    logic [DATA_W:0]   diff;

    // Result of one step, exposed so the owner can capture the final step directly
    always_comb begin
        sum     = {1'b0, acc_q} + (q_q[0] ? {1'b0, b_q} : '0);
        shifted = {acc_q, q_q[DATA_W-1]};
        diff    = shifted - {1'b0, b_q};
        acc_nxt = sum[DATA_W:1];
        q_nxt   = {sum[0], q_q[DATA_W-1:1]};
        if (div_mode) begin
            if (!diff[DATA_W]) begin
                acc_nxt = diff[DATA_W-1:0];
                q_nxt   = {q_q[DATA_W-2:0], 1'b1};
            end else begin
                acc_nxt = shifted[DATA_W-1:0];
                q_nxt   = {q_q[DATA_W-2:0], 1'b0};
            end
        end
    end

    // Load fresh operands or advance the shift registers by one step
    always_comb begin
        acc_d = acc_q;
        q_d   = q_q;
        b_d   = b_q;
        if (load) begin
            acc_d = '0;
            q_d   = a_mag;
            b_d   = b_mag;
        end else if (step) begin
            acc_d = acc_nxt;
            q_d   = q_nxt;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            q_q   <= '0;
            b_q   <= '0;
        end else begin
            acc_q <= acc_d;
            q_q   <= q_d;
            b_q   <= b_d;
        end
    end

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage multiply/divide unit: FSM, iteration counter, sign fix-up,
// architectural HI/LO and the stall request to the hazard unit.
// Optional build macro MULDIV_FAST_MUL_EN: MULT/MULTU complete in a single
// cycle through a `*` operator; DIV/DIVU stay iterative in both builds.
module ex_muldiv_unit
    import ex_muldiv_unit_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              op_valid,
    input  logic [5:0]        alu_control,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] rt_data,
    input  logic              flush,
    output logic              busy,
    output logic              stall_req,
    output logic [DATA_W-1:0] mf_result,
    output logic [DATA_W-1:0] hi_out,
    output logic [DATA_W-1:0] lo_out
);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] hi_q, hi_d;
    logic [DATA_W-1:0] lo_q, lo_d;
    logic              neg_q, neg_d;
    logic              rem_neg_q, rem_neg_d;
    logic              zero_q, zero_d;

    logic              is_mul, is_div, is_signed, accept;
    logic              core_load, core_step, last_step;
    logic              a_neg, b_neg;
    logic [DATA_W-1:0] a_mag, b_mag, acc_nxt, q_nxt;
    logic [2*DATA_W-1:0] prod_mag;
`ifdef MULDIV_FAST_MUL_EN
    logic [2*DATA_W-1:0] fast_a, fast_b, fast_prod;
`endif

    // Decode the function code and form operand magnitudes for a start
    always_comb begin
        is_mul    = (alu_control == FN_MULT) || (alu_control == FN_MULTU);
        is_div    = (alu_control == FN_DIV)  || (alu_control == FN_DIVU);
        is_signed = (alu_control == FN_MULT) || (alu_control == FN_DIV);
        accept    = op_valid && !flush && (state_q == ST_IDLE);
        a_neg     = is_signed && rs_data[DATA_W-1];
        b_neg     = is_signed && rt_data[DATA_W-1];
        a_mag     = a_neg ? -rs_data : rs_data;
        b_mag     = b_neg ? -rt_data : rt_data;
`ifdef MULDIV_FAST_MUL_EN
        core_load = accept && is_div;
        fast_a    = is_signed ? {{DATA_W{rs_data[DATA_W-1]}}, rs_data} : {{DATA_W{1'b0}}, rs_data};
        fast_b    = is_signed ? {{DATA_W{rt_data[DATA_W-1]}}, rt_data} : {{DATA_W{1'b0}}, rt_data};
        fast_prod = fast_a * fast_b;
`else
        core_load = accept && (is_mul || is_div);
`endif
        core_step = (state_q != ST_IDLE);
        last_step = core_step && (cnt_q == CNT_W'(DATA_W - 1));
        prod_mag  = {acc_nxt, q_nxt};
    end

    // FSM next state, counter, sign capture and HI/LO update
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        zero_d    = zero_q;
        if (state_q == ST_IDLE) begin
            if (core_load) begin
                state_d   = is_div ? ST_DIV : ST_MUL;
                cnt_d     = '0;
                neg_d     = a_neg ^ b_neg;
                rem_neg_d = a_neg;
                zero_d    = (rt_data == '0);
            end
`ifdef MULDIV_FAST_MUL_EN
            if (accept && is_mul) begin
                {hi_d, lo_d} = fast_prod;
            end
`endif
            if (accept && (alu_control == FN_MTHI)) begin
                hi_d = rs_data;
            end
            if (accept && (alu_control == FN_MTLO)) begin
                lo_d = rs_data;
            end
        end else if (flush) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else if (last_step) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            if (state_q == ST_MUL) begin
                {hi_d, lo_d} = neg_q ? -prod_mag : prod_mag;
            end else begin
                lo_d = zero_q ? '1 : (neg_q ? -q_nxt : q_nxt);
                hi_d = rem_neg_q ? -acc_nxt : acc_nxt;
            end
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Control and architectural registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            zero_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            zero_q    <= zero_d;
        end
    end

    // Stall and move-from result; an MFHI/MFLO that is stalled reads as zero
    always_comb begin
        busy      = (state_q != ST_IDLE);
        stall_req = busy && op_valid && is_muldiv_fn(alu_control);
        hi_out    = hi_q;
        lo_out    = lo_q;
        mf_result = '0;
        if (op_valid && !stall_req) begin
            if (alu_control == FN_MFHI) begin
                mf_result = hi_q;
            end else if (alu_control == FN_MFLO) begin
                mf_result = lo_q;
            end
        end
    end

    muldiv_iter_core #(
        .DATA_W (DATA_W)
    ) u_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (core_load),
        .step     (core_step),
        .div_mode (state_q == ST_DIV),
        .a_mag    (a_mag),
        .b_mag    (b_mag),
        .acc_nxt  (acc_nxt),
        .q_nxt    (q_nxt)
    );

endmodule
